// File: rtl/wb_arbiter_pkg.sv
// Shared writeback definitions: field widths, the packed commit entry and the
// wrap-aware program-order comparison used to pick the oldest head.
// Pure declarations; no timing or flow-control behaviour of its own.
package wb_arbiter_pkg;

    localparam int WB_PC_W   = 32;
    localparam int WB_DATA_W = 64;
    localparam int WB_RD_W   = 5;
    localparam int WB_SEQ_W  = 4;

    // One buffered writeback, exactly as it will appear on the commit bus.
    typedef struct packed {
        logic [WB_PC_W-1:0]   pc;
        logic [WB_DATA_W-1:0] data;
        logic [WB_RD_W-1:0]   rd;
        logic                 write;
        logic                 incache;
        logic [WB_SEQ_W-1:0]  seq;
    } wb_entry_t;

    // MSB of (b - a) mod 2^SEQ_W: set when b precedes a in program order.
    // Only meaningful while outstanding tags span less than half the tag space.
    function automatic logic seq_older(input logic [WB_SEQ_W-1:0] a,
                                       input logic [WB_SEQ_W-1:0] b);
        logic [WB_SEQ_W-1:0] d;
        d = b - a;
        return d[WB_SEQ_W-1];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer for one writeback source; head is visible combinationally.
// Latency: an entry pushed at edge N is the head from N onward (readable in cycle N+1).
// Backpressure: full_o comes from registered occupancy only; pushes while full are ignored.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   cnt_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Pointer and count state; reset empties the buffer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Buffers exu/lsu writebacks and commits at most one per cycle, oldest tag first.
// Latency: push at edge N, head in N+1, registered wb_valid after edge N+2.
// Backpressure: x_ready = !full from registered occupancy; a same-cycle pop does not raise it.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SEQ_W = WB_SEQ_W
) (
    input  logic                 clk,
    input  logic                 rst_n,       // active-high despite the name
    input  logic                 ex_valid,
    input  logic [WB_PC_W-1:0]   ex_pc,
    input  logic [WB_DATA_W-1:0] ex_data,
    input  logic [WB_RD_W-1:0]   ex_rd,
    input  logic                 ex_write,
    input  logic [SEQ_W-1:0]     ex_seq,
    output logic                 ex_ready,
    input  logic                 ls_valid,
    input  logic [WB_PC_W-1:0]   ls_pc,
    input  logic [WB_DATA_W-1:0] ls_data,
    input  logic [WB_RD_W-1:0]   ls_rd,
    input  logic                 ls_write,
    input  logic [SEQ_W-1:0]     ls_seq,
    input  logic                 ls_incache,
    output logic                 ls_ready,
    output logic                 wb_valid,
    output logic [WB_PC_W-1:0]   wb_pc,
    output logic [WB_DATA_W-1:0] wb_data,
    output logic [WB_RD_W-1:0]   wb_rd,
    output logic                 wb_write,
    output logic                 wb_incache,
    output logic [SEQ_W-1:0]     wb_seq,
    output logic [$clog2(DEPTH):0] ex_cnt,
    output logic [$clog2(DEPTH):0] ls_cnt
);

    wb_entry_t ex_in, ls_in;
    wb_entry_t ex_head, ls_head;
    logic      ex_full, ex_empty, ls_full, ls_empty;
    logic      pick_ex, pick_ls, pop_any;
    wb_entry_t wb_d, wb_q;
    logic      wb_valid_q;

    assign ex_ready = !ex_full;
    assign ls_ready = !ls_full;

    // exu results never touch the dcache, so they commit with incache set.
    always_comb begin
        ex_in         = '0;
        ex_in.pc      = ex_pc;
        ex_in.data    = ex_data;
        ex_in.rd      = ex_rd;
        ex_in.write   = ex_write;
        ex_in.incache = 1'b1;
        ex_in.seq     = ex_seq;
    end

    // lsu entry carries its own dcache indication through to commit.
    always_comb begin
        ls_in         = '0;
        ls_in.pc      = ls_pc;
        ls_in.data    = ls_data;
        ls_in.rd      = ls_rd;
        ls_in.write   = ls_write;
        ls_in.incache = ls_incache;
        ls_in.seq     = ls_seq;
    end

    wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_entry_t))) u_ex_fifo (
        .clk        (clk),
        .rst        (rst_n),
        .push_i     (ex_valid),
        .push_dat_i (ex_in),
        .pop_i      (pick_ex),
        .head_o     (ex_head),
        .full_o     (ex_full),
        .empty_o    (ex_empty),
        .cnt_o      (ex_cnt)
    );

    wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_entry_t))) u_ls_fifo (
        .clk        (clk),
        .rst        (rst_n),
        .push_i     (ls_valid),
        .push_dat_i (ls_in),
        .pop_i      (pick_ls),
        .head_o     (ls_head),
        .full_o     (ls_full),
        .empty_o    (ls_empty),
        .cnt_o      (ls_cnt)
    );

    // Oldest-head selection; ex wins ties, which the dispatcher never produces.
    always_comb begin
        pick_ls = !ls_empty && (ex_empty || seq_older(ex_head.seq, ls_head.seq));
        pick_ex = !ex_empty && !pick_ls;
        pop_any = pick_ex || pick_ls;
        wb_d    = pick_ls ? ls_head : ex_head;
        // Writes to x0 are suppressed here so dc never has to special-case them.
        wb_d.write = wb_d.write && (wb_d.rd != '0);
    end

    // Commit register: wb_valid pulses per pop, payload holds between commits.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            wb_valid_q <= pop_any;
            if (pop_any) begin
                wb_q <= wb_d;
            end
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_pc      = wb_q.pc;
    assign wb_data    = wb_q.data;
    assign wb_rd      = wb_q.rd;
    assign wb_write   = wb_q.write;
    assign wb_incache = wb_q.incache;
    assign wb_seq     = wb_q.seq;

    // Duplicate tags at both heads mean the dispatcher broke its contract.
    a_no_dup_seq: assert property (@(posedge clk) disable iff (rst_n)
        !(!ex_empty && !ls_empty && (ex_head.seq == ls_head.seq)));

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback/commit stage directly downstream of the exu and lsu.
- Replaces the combinational ls-over-ex writeback mux.
- Buffers writebacks from both units in small per-port FIFOs and retires at most one per cycle, oldest first, by wrap-aware sequence tag.
- Drives the registered sideway/commit bus consumed by dc (regfile write, bypass) and the difftest status hook.

Parameters:
- DEPTH, 2, entries per input FIFO (power of two, >=2)
- SEQ_W, 4, width of the program-order sequence tag assigned at dispatch

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (name kept consistent with the other pipeline stages despite the suffix)
- ex_valid  in  1  exu writeback valid
- ex_pc  in  32  exu instruction pc
- ex_data  in  64  exu result
- ex_rd  in  5  destination register
- ex_write  in  1  register write enable
- ex_seq  in  SEQ_W  sequence tag
- ex_ready  out  1  exu FIFO can accept
- ls_valid, ls_pc, ls_data, ls_rd, ls_write, ls_seq  in  1/32/64/5/1/SEQ_W  lsu writeback, same meaning as ex_*
- ls_incache  in  1  load/store went through dcache
- ls_ready  out  1  lsu FIFO can accept
- wb_valid  out  1  one commit this cycle
- wb_pc  out  32  committed pc
- wb_data  out  64  committed data
- wb_rd  out  5  committed rd
- wb_write  out  1  regfile write enable
- wb_incache  out  1  1 for ex commits, ls_incache for ls commits
- wb_seq  out  SEQ_W  committed tag
- ex_cnt, ls_cnt  out  $clog2(DEPTH)+1  FIFO occupancy (debug/perf)

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): both FIFOs empty; all wb_* outputs 0; ex_ready = ls_ready = 1.
- Push:
  - An entry enters its FIFO on x_valid && x_ready.
  - x_ready = !full, computed from registered occupancy only; a same-cycle pop does not raise ready.
  - x_valid while !x_ready is a protocol violation; the producer must hold. Bench asserts this never happens.
- Arbitration each cycle, over FIFO heads only:
  - Both empty: no commit.
  - One non-empty: pop that head.
  - Both non-empty: compute d = ls_head.seq - ex_head.seq mod 2^SEQ_W. If MSB(d) == 1, ls is older and is popped; otherwise ex is popped.
  - Equal tags are illegal (the dispatcher never issues duplicates); on equal tags ex wins and a simulation assertion fires.
- Commit latency:
  - The popped head is registered into wb_*; wb_valid rises the cycle after the pop.
  - Minimum input-to-wb_valid latency is 2 cycles: push at cycle N, head at N+1, wb_valid at N+2.
  - wb_valid is a single-cycle pulse per commit; throughput is 1 commit/cycle.
  - wb_* other than wb_valid hold their last value when no commit occurs.
- x0: wb_write = head.write && (head.rd != 0). wb_data passes through unmodified.
- Order guarantee: wrap-safe while outstanding tags span < 2^(SEQ_W-1). The dispatcher limits in-flight instructions to DEPTH*2 < 8.
- FIFO pointers: log2(DEPTH)-bit read/write pointers that wrap naturally, plus a separate count register. Full when count == DEPTH; empty when count == 0.
- Simultaneous push and pop on the same FIFO: count unchanged; both pointers advance.
- No flush input: everything accepted has already executed and must commit. Branch kill happens upstream in dc/exu.
- Reset mid-operation: FIFO contents and any pending wb_valid are dropped immediately; the first commit after reset is the first post-reset push.

Decomposition:
- Shared package (pipeline defines):
  - WB_PC_W=32, WB_DATA_W=64, WB_RD_W=5
  - SEQ_W default
  - packed wb entry typedef {pc, data, rd, write, incache, seq}
  - function seq_older(a, b), returning MSB(b - a)
- One natural sub-module: wb_fifo (parameterised DEPTH, entry width, push/pop/full/empty/count), instantiated twice.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles, then release -> wb_valid=0, wb_*=0, ex_ready=ls_ready=1, ex_cnt=ls_cnt=0.
- Single ex: ex_valid=1 for one cycle with pc=0x80000000, data=0x1234, rd=5, write=1, seq=3 -> exactly 2 cycles later wb_valid=1, wb_pc=0x80000000, wb_data=0x1234, wb_rd=5, wb_write=1, wb_incache=1; wb_valid low the next cycle.
- Same-cycle both: ex seq=2 rd=1 and ls seq=1 rd=2 incache=0 -> commit ls (wb_seq=1, wb_incache=0) then ex (wb_seq=2) on consecutive cycles.
- Wrap-around: ls seq=15 and ex seq=0 pushed together -> ls commits first (15 older than 0); then ex seq=1 vs ls seq=0 -> ls seq=0 first.
- Full/backpressure: with DEPTH=2, push ex seq 4,5 while ls holds seq 3 and ls pushes nothing more -> ex_ready=0 after two pushes; commits occur in order 3,4,5; ex_ready returns to 1 the cycle after count drops.
- x0 and mid-run reset: ex rd=0 write=1 -> wb_write=0. Assert rst_n while both FIFOs hold entries -> wb_valid=0 immediately, no stale commits after release.
